// File: rtl/pulse_capture.sv
// Two-channel input capture: synchronises cap_in and measures each channel's
// high time (WIDTH) and period (PERIOD) in prescaled ticks, with an 8-bit register bus.
module pulse_capture (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [5:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       bus_cyc,
    input  logic       bus_we,
    input  logic [1:0] cap_in,
    output logic       irq
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH, S_LOW} state_e;

    state_e      state_q [2];
    state_e      state_d [2];
    logic [7:0]  psc_q [2];
    logic [7:0]  psc_d [2];
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];
    logic [15:0] cnt_inc [2];
    logic [15:0] shadow_q [2];
    logic [15:0] shadow_d [2];
    logic [15:0] width_q [2];
    logic [15:0] width_d [2];
    logic [15:0] period_q [2];
    logic [15:0] period_d [2];

    logic [5:0] ctrl_q, ctrl_d;
    logic [7:0] prescale_q, prescale_d;
    logic [1:0] done_q, done_d, ovf_q, ovf_d;
    logic [1:0] meta_q, sync_q, prev_q;
    logic [7:0] temp_q, temp_d;
    logic [7:0] data_out_q, data_out_d;
    logic       irq_q, irq_d;

    logic       wr_ctrl, wr_stat, wr_psc, rd_acc;
    logic [1:0] rise, fall, tick, start, done_set, ovf_set, arm_clr, busy;
    logic [7:0] status, rdata;

    // Bus: every clock with bus_cyc=1 is one complete access (no stall/ready);
    // writes land on that edge, read data appears on data_out one clock later.
    assign wr_ctrl = bus_cyc & bus_we & (addr == 6'd0);
    assign wr_stat = bus_cyc & bus_we & (addr == 6'd1);
    assign wr_psc  = bus_cyc & bus_we & (addr == 6'd2);
    assign rd_acc  = bus_cyc & ~bus_we;

    always_comb begin
        rise     = sync_q & ~prev_q;
        fall     = ~sync_q & prev_q;
        tick     = '0;
        start    = '0;
        done_set = '0;
        ovf_set  = '0;
        arm_clr  = '0;
        busy     = '0;
        for (int n = 0; n < 2; n++) begin
            tick[n]     = (psc_q[n] == prescale_q);
            cnt_inc[n]  = (tick[n] && cnt_q[n] != 16'hFFFF) ? cnt_q[n] + 16'd1 : cnt_q[n];
            busy[n]     = (state_q[n] != S_IDLE);
            state_d[n]  = state_q[n];
            shadow_d[n] = shadow_q[n];
            width_d[n]  = width_q[n];
            period_d[n] = period_q[n];
            case (state_q[n])
                S_IDLE: if (wr_ctrl && data_in[n] && !ctrl_q[n]) state_d[n] = S_ARMED;
                S_ARMED: if (rise[n]) begin
                    state_d[n] = S_HIGH;
                    start[n]   = 1'b1;
                end
                S_HIGH: if (fall[n]) begin
                    shadow_d[n] = cnt_inc[n];
                    state_d[n]  = S_LOW;
                end
                S_LOW: if (rise[n]) begin
                    period_d[n] = cnt_inc[n];
                    width_d[n]  = shadow_q[n];
                    done_set[n] = 1'b1;
                    if (ctrl_q[n+4]) begin
                        state_d[n] = S_HIGH;
                        start[n]   = 1'b1;
                    end else begin
                        state_d[n] = S_IDLE;
                        arm_clr[n] = 1'b1;
                    end
                end
                default: state_d[n] = S_IDLE;
            endcase
            // Software disarm aborts whatever is in flight without publishing a result.
            if (wr_ctrl && !data_in[n]) begin
                state_d[n]  = S_IDLE;
                width_d[n]  = width_q[n];
                period_d[n] = period_q[n];
                done_set[n] = 1'b0;
            end
            if (start[n]) begin
                psc_d[n] = 8'd0;
                cnt_d[n] = 16'd0;
            end else if (tick[n]) begin
                psc_d[n] = 8'd0;
                cnt_d[n] = cnt_inc[n];
            end else begin
                psc_d[n] = psc_q[n] + 8'd1;
                cnt_d[n] = cnt_q[n];
            end
            ovf_set[n] = tick[n] && (cnt_q[n] == 16'hFFFE) &&
                         (state_q[n] == S_HIGH || state_q[n] == S_LOW);
        end
        done_d = (done_q & ~({2{wr_stat}} & data_in[1:0])) | done_set;
        ovf_d  = (ovf_q & ~({2{wr_stat}} & data_in[3:2])) | ovf_set;
        ctrl_d = wr_ctrl ? data_in[5:0] : (ctrl_q & ~{4'b0000, arm_clr});
        prescale_d = wr_psc ? data_in : prescale_q;
        irq_d = |(done_q & ctrl_q[3:2]);
    end

    assign status = {sync_q, busy, ovf_q, done_q};

    always_comb begin
        rdata  = 8'h00;
        temp_d = temp_q;
        case (addr)
            6'd0:  rdata = {2'b00, ctrl_q};
            6'd1:  rdata = status;
            6'd2:  rdata = prescale_q;
            6'd4:  rdata = width_q[0][7:0];
            6'd6:  rdata = period_q[0][7:0];
            6'd8:  rdata = width_q[1][7:0];
            6'd10: rdata = period_q[1][7:0];
            6'd5, 6'd7, 6'd9, 6'd11: rdata = temp_q;
            default: rdata = 8'h00;
        endcase
        if (rd_acc) begin
            case (addr)
                6'd4:  temp_d = width_q[0][15:8];
                6'd6:  temp_d = period_q[0][15:8];
                6'd8:  temp_d = width_q[1][15:8];
                6'd10: temp_d = period_q[1][15:8];
                default: temp_d = temp_q;
            endcase
        end
        data_out_d = bus_cyc ? rdata : data_out_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            done_q     <= '0;
            ovf_q      <= '0;
            meta_q     <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            temp_q     <= '0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                state_q[n]  <= S_IDLE;
                psc_q[n]    <= '0;
                cnt_q[n]    <= '0;
                shadow_q[n] <= '0;
                width_q[n]  <= '0;
                period_q[n] <= '0;
            end
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            meta_q     <= cap_in;
            sync_q     <= meta_q;
            prev_q     <= sync_q;
            temp_q     <= temp_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
            for (int n = 0; n < 2; n++) begin
                state_q[n]  <= state_d[n];
                psc_q[n]    <= psc_d[n];
                cnt_q[n]    <= cnt_d[n];
                shadow_q[n] <= shadow_d[n];
                width_q[n]  <= width_d[n];
                period_q[n] <= period_d[n];
            end
        end
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;
endmodule
